// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall codes, exception codes, reset level and FSM states
// shared by the pipeline controller and its watchdog.
package pipe_ctrl_pkg;
    localparam logic RstLevel = 1'b0;
    localparam logic [5:0] StallMem  = 6'b011111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallIf   = 6'b000111;
    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [31:0] ExcEret    = 32'h0000000e;
    localparam logic [31:0] ExcInt     = 32'h00000001;
    localparam logic [31:0] ExcSyscall = 32'h00000008;
    localparam logic [31:0] ExcInvalid = 32'h0000000a;
    localparam logic [31:0] ExcTrap    = 32'h0000000d;
    localparam logic [31:0] ExcOv      = 32'h0000000c;
    typedef enum logic {PipeRun = 1'b0, PipeFlush = 1'b1} pipe_state_e;
    // Later stages win so an earlier stage never advances into a stopped one.
    function automatic logic [5:0] stall_code(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
        return req_mem ? StallMem : req_ex ? StallEx : req_id ? StallId : req_if ? StallIf : StallNone;
    endfunction
endpackage

// File: rtl/pipe_stall_watchdog.sv
// pipe_stall_watchdog: saturating count of consecutive stalled cycles with a
// sticky timeout flag; timeout_clr beats a simultaneous set.
module pipe_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    input  logic clear,
    input  logic timeout_clr,
    output logic stall_timeout
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst == RstLevel) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else begin
            cnt           <= clear ? '0 : (stalled && cnt != '1) ? cnt + CNT_W'(1) : cnt;
            stall_timeout <= timeout_clr ? 1'b0 :
                             (stalled && cnt == CNT_W'(STALL_TIMEOUT - 1)) ? 1'b1 : stall_timeout;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with multi-cycle flush sequencer,
// stall watchdog and saturating exception counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES  = 1,
    parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
    parameter int          STALL_TIMEOUT = 1024,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             timeout_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             flush_busy,
    output logic [CNT_W-1:0] exc_count,
    output logic             stall_timeout
);
    pipe_state_e state;
    logic [3:0]  cnt;
    logic [31:0] new_pc_q;
    logic        active;
    logic        exc;
    logic        leave;
    always_comb begin
        active = rst != RstLevel;
        exc    = state == PipeRun && excepttype_i != 32'h0;
        leave  = state == PipeFlush && cnt == 4'd1;
        flush  = active && (exc || state == PipeFlush);
        stall  = (!active || flush) ? StallNone :
                 stall_code(stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem);
        new_pc = !flush ? 32'h0 : state == PipeFlush ? new_pc_q :
                 excepttype_i == ExcEret ? cp0_epc_i : EXC_VECTOR;
    end
    always_ff @(posedge clk) begin
        if (rst == RstLevel) begin
            state      <= PipeRun;
            cnt        <= 4'd0;
            new_pc_q   <= 32'h0;
            flush_busy <= 1'b0;
            exc_count  <= '0;
        end else if (state == PipeRun) begin
            if (exc) begin
                new_pc_q   <= new_pc;
                cnt        <= 4'(FLUSH_CYCLES - 1);
                exc_count  <= exc_count != '1 ? exc_count + CNT_W'(1) : exc_count;
                state      <= FLUSH_CYCLES > 1 ? PipeFlush : PipeRun;
                flush_busy <= FLUSH_CYCLES > 1;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (leave) begin
                state      <= PipeRun;
                flush_busy <= 1'b0;
            end
        end
    end
    pipe_stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT), .CNT_W(CNT_W)) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .stalled      (active && state == PipeRun && !exc && stall != StallNone),
        .clear        (stall == StallNone || flush || leave),
        .timeout_clr  (timeout_clr),
        .stall_timeout(stall_timeout)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus random stimulus; a cycle-level reference model
// pushes expected outputs that a separate monitor pops and compares.
module tb_pipe_ctrl;
    localparam int FC = 3;
    localparam int TO = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [5:0]    stall;
        logic          flush;
        logic [31:0]   pc;
        logic          busy;
        logic [CW-1:0] cnt;
        logic          to;
    } exp_t;

    logic clk = 0;
    logic rst = 0;
    logic stallreq_from_if = 0, stallreq_from_id = 0, stallreq_from_ex = 0, stallreq_from_mem = 0;
    logic [31:0] excepttype_i = 0, cp0_epc_i = 0;
    logic timeout_clr = 0;
    logic [5:0] stall;
    logic flush, flush_busy, stall_timeout;
    logic [31:0] new_pc;
    logic [CW-1:0] exc_count;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .EXC_VECTOR(32'h20), .STALL_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_id(stallreq_from_id),
        .stallreq_from_ex(stallreq_from_ex), .stallreq_from_mem(stallreq_from_mem),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i), .timeout_clr(timeout_clr),
        .stall(stall), .flush(flush), .new_pc(new_pc), .flush_busy(flush_busy),
        .exc_count(exc_count), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // model state: remaining flush cycles, saved target, accepted exceptions,
    // current run of stalled cycles, sticky timeout
    int m_left = 0, m_exc = 0, m_run = 0;
    logic [31:0] m_pc = 0;
    logic m_to = 0;

    task automatic cyc(input logic r, input logic [3:0] req, input logic [31:0] exc,
                       input logic [31:0] epc, input logic clr);
        exp_t e;
        logic set;
        @(negedge clk);
        rst = r;
        {stallreq_from_mem, stallreq_from_ex, stallreq_from_id, stallreq_from_if} = req;
        excepttype_i = exc;
        cp0_epc_i = epc;
        timeout_clr = clr;
        e.busy = m_left > 0;
        e.cnt = CW'(m_exc);
        e.to = m_to;
        e.stall = 6'h00;
        e.flush = 1'b0;
        e.pc = 32'h0;
        set = 1'b0;
        if (!r) begin
            m_left = 0; m_exc = 0; m_run = 0; m_to = 0;
        end else begin
            if (m_left > 0) begin
                e.flush = 1'b1; e.pc = m_pc; m_left--; m_run = 0;
            end else if (exc != 0) begin
                e.flush = 1'b1;
                e.pc = exc == 32'he ? epc : 32'h20;
                m_pc = e.pc;
                m_left = FC - 1;
                if (m_exc < CMAX) m_exc++;
                m_run = 0;
            end else begin
                e.stall = req[3] ? 6'h1f : req[2] ? 6'h0f : (req[1] || req[0]) ? 6'h07 : 6'h00;
                if (e.stall != 0) begin
                    m_run++;
                    set = m_run == TO;
                end else m_run = 0;
            end
            m_to = clr ? 1'b0 : set ? 1'b1 : m_to;
        end
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("flush", 32'(flush), 32'(e.flush));
            chk("new_pc", new_pc, e.pc);
            chk("flush_busy", 32'(flush_busy), 32'(e.busy));
            chk("exc_count", 32'(exc_count), 32'(e.cnt));
            chk("stall_timeout", 32'(stall_timeout), 32'(e.to));
        end
    end

    initial begin
        logic [31:0] codes [7];
        codes = '{32'h1, 32'h8, 32'ha, 32'hd, 32'hc, 32'he, 32'h0};
        repeat (3) cyc(0, 4'hf, 32'h8, 32'h1234, 0);
        cyc(1, 4'b1010, 0, 0, 0);
        cyc(1, 4'b0010, 0, 0, 0);
        cyc(1, 4'b0000, 0, 0, 0);
        cyc(1, 4'b0100, 32'hc, 0, 0);
        repeat (3) cyc(1, 4'b0100, 0, 0, 0);
        cyc(1, 0, 32'he, 32'h00400104, 0);
        cyc(1, 0, 32'h8, 32'h0, 0);
        cyc(1, 0, 32'h8, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);
        repeat (8) cyc(1, 4'b1000, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        repeat (7) cyc(1, 4'b1000, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (7) cyc(1, 4'b0001, 0, 0, 0);
        cyc(1, 4'b0001, 0, 0, 1);
        repeat (2) cyc(1, 4'b0001, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (17 * FC) cyc(1, 4'b0011, 32'h1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 32'hd, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ex;
            ex = ($urandom_range(0, 11) == 0) ? codes[$urandom_range(0, 5)] : 32'h0;
            if ($urandom_range(0, 40) == 0) ex = $urandom | 32'h100;
            cyc($urandom_range(0, 63) != 0, 4'($urandom), ex, $urandom, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 40; i++)
            cyc(1, {($urandom_range(0, 15) != 0), 3'b000}, 0, 0, i == 30);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the six-stage core (pc, if, id, ex, mem, wb).
- Takes stall requests from the stages and the exception type resolved at mem.
- Drives the stall[5:0] vector and the flush pulse consumed by every inter-stage register (if_id, id_ex, ex_mem, mem_wb), plus the redirect PC.
- Adds a multi-cycle flush sequencer, a stall watchdog and an exception counter.

Parameters:
- FLUSH_CYCLES, 1, cycles flush stays asserted per exception; legal range 1..15.
- EXC_VECTOR, 32'h00000020, redirect target for every exception except ERET.
- STALL_TIMEOUT, 1024, consecutive stalled cycles that trip the watchdog; must be at least 1.
- CNT_W, 16, width of the watchdog counter and of exc_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a clk edge resets.
- stallreq_from_if  in  1  fetch stage waiting, e.g. on the instruction bus.
- stallreq_from_id  in  1  decode load-use hazard.
- stallreq_from_ex  in  1  ex multi-cycle op (div, madd/msub).
- stallreq_from_mem  in  1  data bus wait.
- excepttype_i  in  32  final exception type from mem; 0 means none; 32'h0000000e means ERET.
- cp0_epc_i  in  32  current EPC from CP0.
- timeout_clr  in  1  clears the sticky stall_timeout.
- stall  out  6  per-stage hold; bit0 pc … bit5 wb; 1 means Stop.
- flush  out  1  clears every pipeline register.
- new_pc  out  32  redirect address; valid only while flush==1.
- flush_busy  out  1  high while in state FLUSH (registered cycles only).
- exc_count  out  CNT_W  count of accepted exceptions; saturates at all-ones.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst==0 at edge):
  - state<=RUN; flush counter, watchdog counter, exc_count and stall_timeout all <=0.
  - While rst==0, the combinational outputs are forced: stall=0, flush=0, new_pc=0.
- FSM states:
  - RUN -> FLUSH when excepttype_i!=0 and FLUSH_CYCLES>1.
  - RUN stays in RUN when excepttype_i!=0 and FLUSH_CYCLES==1 (single-cycle pulse).
  - FLUSH -> RUN when the remaining-cycle counter reaches 0.
- Exception acceptance in RUN:
  - Acceptance is the cycle excepttype_i!=0. In that same cycle, combinationally: flush=1, stall=0.
  - new_pc = cp0_epc_i if excepttype_i==32'he, else EXC_VECTOR.
  - new_pc is latched into new_pc_q. Counter is loaded with FLUSH_CYCLES-1. exc_count increments by 1 unless saturated.
- In FLUSH:
  - flush=1, stall=0, new_pc=new_pc_q (a later EPC change is ignored), flush_busy=1.
  - Counter decrements each cycle; excepttype_i and all stall requests are ignored.
  - Total flush width is exactly FLUSH_CYCLES cycles, counting the acceptance cycle.
- Stall encoding (RUN, no exception), combinational, priority mem > ex > id > if:
  - mem: 6'b011111.
  - ex: 6'b001111.
  - id: 6'b000111.
  - if: 6'b000111.
  - none: 6'b000000.
  - Stages are never stalled in a pattern where a later stage stops while an earlier one advances.
- Simultaneous exception and stall request: the exception wins (flush=1, stall=0).
- Watchdog:
  - Counter increments when state==RUN, no exception and stall!=0; it saturates.
  - Counter clears in any cycle with stall==0, with flush==1, or when the FSM leaves FLUSH.
  - stall_timeout sets on the edge where the counter equals STALL_TIMEOUT-1 and stall is still !=0. It is therefore visible after STALL_TIMEOUT consecutive stalled cycles.
  - stall_timeout stays set until timeout_clr==1 or reset. If timeout_clr and a set condition occur in the same cycle, clr wins.
- Reset mid-flush: FSM returns to RUN at the edge, flush deasserts immediately and no residual pulse follows.
- exc_count is never decremented; it wraps only via reset.

Decomposition:
- defines.v additions:
  - Stall codes: StallMem, StallEx, StallId, StallIf, StallNone.
  - Exception codes: ExcEret=32'he, ExcInt=32'h1, ExcSyscall=32'h8, ExcInvalid=32'ha, ExcTrap=32'hd, ExcOv=32'hc.
  - Reset-level macro for the active-low reset.
  - FSM state encodings PipeRun and PipeFlush.
- One sub-module, pipe_stall_watchdog: the saturating counter plus the sticky flag. Its inputs are clk, rst, stalled, clear and timeout_clr.

Test Plan:
- Reset: hold rst=0 for 3 cycles with every stall request and excepttype_i=32'h8 -> stall=0, flush=0, new_pc=0, exc_count=0. After release, outputs follow inputs.
- Priority: stallreq_from_id=1 and stallreq_from_mem=1 -> stall=6'b011111. Drop mem -> 6'b000111. Drop id -> 6'b000000.
- Exception vs stall: stallreq_from_ex=1 plus excepttype_i=32'hc with FLUSH_CYCLES=3 -> flush=1 for exactly 3 cycles, new_pc=32'h20 throughout, stall=0, exc_count=1.
- ERET: cp0_epc_i=32'h00400104, excepttype_i=32'he, then cp0_epc_i changes to 32'h0 on the next cycle -> new_pc stays 32'h00400104 for all flush cycles. A second exception during FLUSH is ignored (exc_count unchanged).
- Watchdog: STALL_TIMEOUT=8, stallreq_from_mem held 8 cycles -> stall_timeout=1 after the 8th edge. With 7 cycles then one free cycle, it stays 0. timeout_clr=1 clears it.
- Saturation and mid-flush reset: CNT_W=4 with 17 exceptions -> exc_count=15. rst=0 during FLUSH -> flush=0 immediately, state RUN.
